shift_pipe_ctrl: RTL and testbench
==================================

// Module: shift_pipe_ctrl
// PURPOSE
//   Valid/ready flow controller for a STAGES-deep, uniformly shifting data shift register.
//   Drives that register's enable and tracks a shadow valid bit per stage.
//   Gives the data pipe an elastic handshake: it stalls on downstream back-pressure, and supports drain and flush.
//   Sits between the producer, the data shift register and the consumer; it carries no data itself.
// PARAMETERS
//   STAGES  3                        depth of the controlled shift register (>=1)
//   CNT_W   $clog2(STAGES+1) (local) width of the occupancy count
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      async, active-high; clears all state
//   in_valid     in   1      producer has data on the shift register din
//   in_ready     out  1      controller accepts din this cycle (combinational)
//   out_valid    out  1      shift register dout holds a valid item
//   out_ready    in   1      consumer takes dout this cycle
//   drain        in   1      1-cycle pulse: stop accepting, empty the pipe
//   flush        in   1      1-cycle pulse: discard all in-flight items
//   sr_enable    out  1      to the shift register enable (combinational)
//   occupancy    out  CNT_W  number of valid items in the pipe
//   busy         out  1      state!=IDLE or occupancy!=0
//   drained      out  1      registered 1-cycle pulse: drain complete
//   stall_count  out  16     saturating count of stall cycles
// BEHAVIOUR
//   Reset (async, any time): vld=0, occupancy=0, state=IDLE, drained=0, stall_count=0.
//     Hence out_valid=0 and busy=0; in_ready and sr_enable follow the comb rules below.
//   vld[STAGES-1:0] shadows the data stages; out_valid = vld[STAGES-1].
//   stall     = out_valid & ~out_ready.
//   in_ready  = ~stall & (state!=DRAIN) & ~flush.
//   accept    = in_valid & in_ready;  take = out_valid & out_ready.
//   sr_enable = ~stall & ~flush & (accept | (|vld)).
//     The register shifts only when something must move.
//   On sr_enable: vld <= {vld[STAGES-2:0], accept}; for STAGES=1, vld <= accept.
//     Bubbles are NOT collapsed; every stage shifts together.
//   Latency: an item accepted in cycle c shows out_valid in cycle c+STAGES if unstalled.
//     Each stall cycle on the path adds one cycle.
//   occupancy: +1 on accept, -1 on take, unchanged when both occur in the same cycle.
//     It never exceeds STAGES.
//   stall_count: +1 in each cycle with stall=1; holds at 16'hFFFF; cleared only by reset.
//   FSM (2-bit): IDLE, RUN, DRAIN
//     IDLE : occupancy==0. On accept -> RUN.
//     RUN  : when next occupancy==0 -> IDLE.
//     DRAIN: in_ready=0; the pipe keeps shifting and delivering.
//       When occupancy==0 -> IDLE, and drained=1 in the following cycle.
//     drain in IDLE or RUN -> DRAIN, even if the pipe is empty; drained then pulses 2 cycles after the drain pulse.
//     drain while already in DRAIN: ignored.
//   flush (highest priority, synchronous): next edge vld=0, occupancy=0, state=IDLE.
//     In the flush cycle in_ready=0 and sr_enable=0.
//     The flushed dout may still hold stale data, but out_valid=0 masks it.
//     No drained pulse when flush aborts a drain.
//     flush and drain in the same cycle: flush wins, drain is dropped.
//   Simultaneous accept+take with a full pipe: allowed; the pipe stays full; occupancy stays STAGES.
//   Full pipe with out_ready=0: in_ready=0 and sr_enable=0; all state holds.
// TESTING
//   1 Stream of 3 items, out_ready=1, STAGES=3: accept c0..c2
//       -> out_valid c3..c5; occupancy peaks at 3; sr_enable low from c6.
//   2 Fill 3, hold out_ready=0 for 4 cycles
//       -> in_ready=0 and sr_enable=0; stall_count=4; release -> items exit in order.
//   3 2 items in flight, pulse drain
//       -> in_ready=0 thereafter; drained pulses 1 cycle after occupancy hits 0; state=IDLE.
//   4 Full pipe, pulse flush together with drain
//       -> next cycle occupancy=0, out_valid=0, no drained pulse.
//   5 Assert reset mid-stream with a stall active
//       -> immediately out_valid=0, occupancy=0, stall_count=0, busy=0.
//   6 Force 70000 stall cycles -> stall_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/shift_pipe_ctrl.sv
// Valid/ready flow controller for a uniformly shifting data shift register.
// Tracks a shadow valid bit per stage and handles stall, drain and flush.
module shift_pipe_ctrl #(
    parameter  int STAGES = 3,
    localparam int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             drain,
    input  logic             flush,
    output logic             sr_enable,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy,
    output logic             drained,
    output logic [15:0]      stall_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [STAGES-1:0] r_vld;
    logic [CNT_W-1:0]  r_occ;
    logic [1:0]        r_state;
    logic              r_drained;
    logic [15:0]       r_stall_cnt;

    logic              w_stall;
    logic              w_accept;
    logic              w_take;
    logic [STAGES-1:0] w_vld_shift;
    logic [CNT_W-1:0]  w_occ_nxt;
    logic [1:0]        w_state_nxt;
    logic              w_drained_nxt;

    assign out_valid = r_vld[STAGES-1];
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall & (r_state != S_DRAIN) & ~flush;
    assign w_accept  = in_valid & in_ready;
    assign w_take    = out_valid & out_ready;
    // Shift only when an item enters or something is already in flight.
    assign sr_enable = ~w_stall & ~flush & (w_accept | (|r_vld));

    generate
        if (STAGES == 1) begin : g_one
            assign w_vld_shift = w_accept;
        end else begin : g_many
            assign w_vld_shift = {r_vld[STAGES-2:0], w_accept};
        end
    endgenerate

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_accept && !w_take) begin
            w_occ_nxt = r_occ + CNT_W'(1);
        end else if (!w_accept && w_take) begin
            w_occ_nxt = r_occ - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_drained_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (drain) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (drain) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_occ_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (r_occ == '0) begin
                    w_state_nxt   = S_IDLE;
                    w_drained_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush aborts everything, including a pending drain completion.
        if (flush) begin
            w_state_nxt   = S_IDLE;
            w_drained_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld     <= '0;
            r_occ     <= '0;
            r_state   <= S_IDLE;
            r_drained <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_drained <= w_drained_nxt;
            if (flush) begin
                r_vld <= '0;
                r_occ <= '0;
            end else if (sr_enable) begin
                r_vld <= w_vld_shift;
                r_occ <= w_occ_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign occupancy   = r_occ;
    assign busy        = (r_state != S_IDLE) | (r_occ != '0);
    assign drained     = r_drained;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Bench for shift_pipe_ctrl: item-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_shift_pipe_ctrl;

    localparam int STAGES = 3;
    localparam int CNT_W  = $clog2(STAGES + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             drain;
    logic             flush;
    logic             sr_enable;
    logic [CNT_W-1:0] occupancy;
    logic             busy;
    logic             drained;
    logic [15:0]      stall_count;

    shift_pipe_ctrl #(.STAGES(STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .drain       (drain),
        .flush       (flush),
        .sr_enable   (sr_enable),
        .occupancy   (occupancy),
        .busy        (busy),
        .drained     (drained),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each in-flight item is its position (1..STAGES), oldest first.
    int q[$];
    bit m_drain   = 1'b0;
    bit m_drained = 1'b0;
    int m_stall   = 0;

    function automatic bit m_ov();
        return (q.size() > 0) && (q[0] == STAGES);
    endfunction

    initial begin : model
        bit st;
        bit irdy;
        bit acc;
        bit tk;
        bit sh;
        bit was_empty;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_drain   = 1'b0;
                m_drained = 1'b0;
                m_stall   = 0;
            end else begin
                st        = m_ov() && !out_ready;
                irdy      = !st && !m_drain && !flush;
                acc       = in_valid && irdy;
                tk        = m_ov() && out_ready;
                sh        = !st && !flush && (acc || q.size() > 0);
                was_empty = (q.size() == 0);
                if (st && m_stall < 65535) m_stall++;
                m_drained = m_drain && was_empty && !flush;
                if (flush) begin
                    q.delete();
                    m_drain = 1'b0;
                end else begin
                    if (sh) begin
                        if (tk) void'(q.pop_front());
                        foreach (q[i]) q[i]++;
                        if (acc) q.push_back(1);
                    end
                    if (m_drain) begin
                        if (was_empty) m_drain = 1'b0;
                    end else if (drain) begin
                        m_drain = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : compare
        bit st;
        bit irdy;
        bit acc;
        bit sr;
        forever begin
            @(negedge clk);
            st   = m_ov() && !out_ready;
            irdy = !st && !m_drain && !flush;
            acc  = in_valid && irdy;
            sr   = !st && !flush && (acc || q.size() > 0);
            chk("m_out_valid", out_valid, m_ov());
            chk("m_in_ready", in_ready, irdy);
            chk("m_sr_enable", sr_enable, sr);
            chk("m_occupancy", occupancy, q.size());
            chk("m_busy", busy, m_drain || q.size() != 0);
            chk("m_drained", drained, m_drained);
            chk("m_stall_count", stall_count, m_stall);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drain     = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int ov1[7]   = '{0, 0, 0, 1, 1, 1, 0};
        int oc1[7]   = '{0, 1, 2, 3, 2, 1, 0};
        int sr1[7]   = '{1, 1, 1, 1, 1, 1, 0};
        int ov2[11]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        int oc2[11]  = '{0, 1, 2, 3, 3, 3, 3, 3, 2, 1, 0};
        int oc3[8]   = '{0, 1, 2, 2, 1, 0, 0, 0};
        int ir3[8]   = '{1, 1, 1, 0, 0, 0, 1, 1};
        int dr3[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};
        int bz3[8]   = '{0, 1, 1, 1, 1, 1, 0, 0};

        reset = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sr_enable", sr_enable, 0);

        // Stream of three items with a free-running consumer.
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 3);
            @(negedge clk);
            chk("t1_out_valid", out_valid, ov1[c]);
            chk("t1_occupancy", occupancy, oc1[c]);
            chk("t1_sr_enable", sr_enable, sr1[c]);
            tick();
        end

        // Fill, then four cycles of back-pressure.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            in_valid  = (c < 3) || (c == 4);
            out_ready = (c >= 7);
            @(negedge clk);
            chk("t2_out_valid", out_valid, ov2[c]);
            chk("t2_occupancy", occupancy, oc2[c]);
            if (c >= 3 && c <= 6) begin
                chk("t2_in_ready", in_ready, 0);
                chk("t2_sr_enable", sr_enable, 0);
            end
            if (c == 7) chk("t2_stall_count", stall_count, 4);
            tick();
        end
        in_valid = 1'b0;

        // Drain with two items in flight.
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 2);
            drain    = (c == 2);
            @(negedge clk);
            chk("t3_occupancy", occupancy, oc3[c]);
            chk("t3_in_ready", in_ready, ir3[c]);
            chk("t3_drained", drained, dr3[c]);
            chk("t3_busy", busy, bz3[c]);
            tick();
        end
        drain = 1'b0;

        // Flush and drain together on a full, stalled pipe.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            flush    = (c == 3);
            drain    = (c == 3);
            @(negedge clk);
            if (c == 3) begin
                chk("t4_occ_full", occupancy, 3);
                chk("t4_in_ready", in_ready, 0);
                chk("t4_sr_enable", sr_enable, 0);
            end
            if (c == 4) begin
                chk("t4_occupancy", occupancy, 0);
                chk("t4_out_valid", out_valid, 0);
                chk("t4_busy", busy, 0);
            end
            if (c >= 4) chk("t4_drained", drained, 0);
            tick();
        end

        // Asynchronous reset mid-stream during a stall.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 3);
            tick();
        end
        @(negedge clk);
        chk("t5_pre_stall", stall_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_occupancy", occupancy, 0);
        chk("t5_stall_count", stall_count, 0);
        chk("t5_busy", busy, 0);
        tick();
        reset = 1'b0;

        // Randomized traffic with occasional drain and flush pulses.
        do_reset();
        repeat (4000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            drain     = ($urandom_range(0, 39) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            tick();
        end
        in_valid = 1'b0;
        drain    = 1'b0;
        flush    = 1'b0;

        // Long stall to saturate the counter.
        do_reset();
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        @(negedge clk);
        chk("t6_saturate", stall_count, 16'hFFFF);
        out_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
